tmds_encode: RTL and testbench
==============================

Name: tmds_encode

Overview:
- Single-channel DVI/TMDS 8b/10b encoder. It sits directly downstream of the VGA timing controller in the HDMI colour-bar path.
- Three instances, one per colour channel, take 8-bit pixel data and the hsync/vsync control bits from the timing controller. Each produces a DC-balanced, transition-minimised 10-bit symbol for the serialiser.
- During blanking it emits the four TMDS control tokens.

Parameters:
None. The algorithm and token values are fixed by DVI 1.0.

Ports:
vga_clk    input   1   pixel clock; all registers on rising edge
sys_rst_n  input   1   asynchronous active-low reset
data_in    input   8   pixel byte for this channel (the instantiating level expands RGB565 to 8 bits)
c0         input   1   control bit 0 (hsync on blue channel, 0 on others)
c1         input   1   control bit 1 (vsync on blue channel, 0 on others)
de         input   1   data enable (rgb_valid from timing controller)
data_out   output  10  registered TMDS symbol, bit 0 transmitted first

Behaviour:
- Clock and reset: single clock domain, vga_clk. Reset is asynchronous, active-low on sys_rst_n.
- Reset values: every register is cleared, including all pipeline stages, the disparity counter cnt and data_out. So data_out = 10'd0 and cnt = 0.
  - Reset asserted mid-stream clears everything immediately.
  - After release, the first valid symbol appears per normal latency.
- Pipeline: three register stages. Inputs sampled at edge N appear encoded on data_out after edge N+2. Throughput is one symbol per clock with no stalls. de, c0 and c1 are delayed alongside the data.
- Stage 1:
  - register data_in as d, plus de/c0/c1;
  - register n1d = number of ones in data_in (4-bit).
- Stage 2, transition minimisation:
  - ctrl = (n1d > 4) OR (n1d == 4 AND d[0] == 0).
  - q_m[0] = d[0].
  - For i = 1..7: q_m[i] = ctrl ? XNOR(q_m[i-1], d[i]) : XOR(q_m[i-1], d[i]).
  - q_m[8] = NOT ctrl.
  - Register q_m (9-bit) plus delayed de/c0/c1.
- Stage 3, DC balance:
  - n1q and n0q are the counts of ones and zeros in q_m[7:0].
  - cnt is a 5-bit two's-complement running disparity.
  - All disparity arithmetic is done in 5-bit signed; the result never exceeds ±16.
- Stage 3 when delayed de = 0:
  - cnt <= 0.
  - data_out <= token per {c1,c0}: 00 -> 10'b1101010100, 01 -> 10'b0010101011, 10 -> 10'b0101010100, 11 -> 10'b1010101011.
- Stage 3 when de = 1, case A: (cnt == 0) OR (n1q == n0q).
  - data_out <= {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  - cnt <= q_m[8] ? cnt + (n1q - n0q) : cnt + (n0q - n1q).
- Stage 3 when de = 1, case B: (cnt > 0 AND n1q > n0q) OR (cnt < 0 AND n0q > n1q).
  - data_out <= {1, q_m[8], ~q_m[7:0]}.
  - cnt <= cnt + 2*q_m[8] + (n0q - n1q).
- Stage 3 when de = 1, otherwise:
  - data_out <= {0, q_m[8], q_m[7:0]}.
  - cnt <= cnt - 2*(~q_m[8]) + (n1q - n0q).
- de edges: the first symbol after de rises always sees cnt = 0, because blanking forced cnt to 0. A single-cycle de pulse is legal and yields exactly one data symbol.
- No state machine beyond cnt. The block is fully deterministic given the input stream.

Test Plan:
- Reset: hold sys_rst_n low with random inputs -> data_out = 0 throughout.
- Reset mid-stream: assert reset during a de=1 stream, release, then drive de=1 with 8'h00 -> data_out = 10'h100 exactly 3 edges later (cnt restarted at 0).
- Control tokens: de=0, {c1,c0} stepping 00, 01, 10, 11 on successive clocks -> data_out = 0x354, 0x0AB, 0x154, 0x2AB, each arriving 3 edges after its input.
- Disparity tracking: after blanking, de=1 with data_in = 8'h00 for 3 clocks -> data_out = 0x100, 0x3FF, 0x100 (internal cnt = -8, 2, -6).
- All-ones: after blanking, de=1 with data_in = 8'hFF for 1 clock -> data_out = 0x200, cnt = -8. Then de=0 with c=00 -> 0x354 and cnt = 0.
- Reference-model sweep: random 8-bit data in de bursts of 640 with 160-cycle blanking, c0/c1 random, over 10k cycles.
  - data_out must match the DVI 1.0 reference model bit-exactly at 3-cycle latency.
  - Decoding each symbol must recover data_in.
  - |cnt| <= 8 at the end of every burst.

Source files
------------

// File: rtl/tmds_encode.sv
// tmds_encode: DVI 1.0 TMDS 8b/10b encoder for one colour channel.
// Ports: vga_clk/sys_rst_n clock and async low reset; data_in pixel byte;
//        c0/c1 control bits; de data enable; data_out 10-bit symbol, 3-stage.
module tmds_encode (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] data_in,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  output logic [9:0] data_out
);

  // stage 1
  logic [7:0] d1_q;
  logic [3:0] n1d_d, n1d_q;
  logic       de1_q;
  logic [1:0] c1_q;

  // stage 2
  logic       ctrl;
  logic [8:0] qm_d, qm_q;
  logic       de2_q;
  logic [1:0] c2_q;

  // stage 3
  logic [3:0]        n1q, n0q;
  logic signed [4:0] diff, two_q8, two_nq8;
  logic signed [4:0] cnt_d, cnt_q;
  logic [9:0]        dout_d, dout_q;
  logic              sel_a, sel_b;

  always_comb begin
    n1d_d = '0;
    for (int i = 0; i < 8; i++)
      n1d_d = n1d_d + {3'b0, data_in[i]};
  end

  always_comb begin
    ctrl = (n1d_q > 4'd4) || (n1d_q == 4'd4 && !d1_q[0]);
    qm_d = '0;
    qm_d[0] = d1_q[0];
    for (int i = 1; i < 8; i++)
      qm_d[i] = ctrl ? ~(qm_d[i-1] ^ d1_q[i])
                     :  (qm_d[i-1] ^ d1_q[i]);
    qm_d[8] = ~ctrl;
  end

  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++)
      n1q = n1q + {3'b0, qm_q[i]};
    n0q     = 4'd8 - n1q;
    // ones minus zeros, range -8..8
    diff    = signed'({1'b0, n1q}) - signed'({1'b0, n0q});
    two_q8  = signed'({3'b0, qm_q[8], 1'b0});
    two_nq8 = signed'({3'b0, ~qm_q[8], 1'b0});
    sel_a   = (cnt_q == 5'sd0) || (diff == 5'sd0);
    sel_b   = (cnt_q > 5'sd0 && diff > 5'sd0)
           || (cnt_q < 5'sd0 && diff < 5'sd0);
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    if (!de2_q) begin
      // blanking resets disparity so each burst starts balanced
      cnt_d = '0;
      unique case (c2_q)
        2'b00: dout_d = 10'b1101010100;
        2'b01: dout_d = 10'b0010101011;
        2'b10: dout_d = 10'b0101010100;
        2'b11: dout_d = 10'b1010101011;
      endcase
    end else begin
      unique case (1'b1)
        sel_a: begin
          dout_d = {~qm_q[8], qm_q[8],
                    qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d  = qm_q[8] ? cnt_q + diff : cnt_q - diff;
        end
        sel_b: begin
          dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d  = cnt_q + two_q8 - diff;
        end
        default: begin
          dout_d = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d  = cnt_q - two_nq8 + diff;
        end
      endcase
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      d1_q   <= '0;
      n1d_q  <= '0;
      de1_q  <= 1'b0;
      c1_q   <= '0;
      qm_q   <= '0;
      de2_q  <= 1'b0;
      c2_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      d1_q   <= data_in;
      n1d_q  <= n1d_d;
      de1_q  <= de;
      c1_q   <= {c1, c0};
      qm_q   <= qm_d;
      de2_q  <= de1_q;
      c2_q   <= c1_q;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_tmds_encode.sv
// tb_tmds_encode: directed vectors plus reference-model sweep
// for the single-channel TMDS encoder.
module tb_tmds_encode;

  logic       vga_clk;
  logic       sys_rst_n;
  logic [7:0] data_in;
  logic       c0, c1, de;
  logic [9:0] data_out;

  int n_chk;
  int n_pass;
  int rcnt;

  typedef struct packed {
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
    logic       last;
  } vec_t;

  vec_t pq[$];

  tmds_encode dut (
    .vga_clk  (vga_clk),
    .sys_rst_n(sys_rst_n),
    .data_in  (data_in),
    .c0       (c0),
    .c1       (c1),
    .de       (de),
    .data_out (data_out)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)",
               tag, $signed(got), got, $signed(exp), exp);
  endtask

  task automatic drive(input logic e, input logic [1:0] c,
                       input logic [7:0] d);
    de      = e;
    c1      = c[1];
    c0      = c[0];
    data_in = d;
  endtask

  task automatic tick;
    @(posedge vga_clk);
    #1;
  endtask

  // DVI 1.0 reference encoder, integer disparity
  task automatic ref_enc(input logic e, input logic [1:0] c,
                         input logic [7:0] d,
                         output logic [9:0] sym);
    int n1, n1q, n0q;
    logic use_xnor;
    logic [8:0] qm;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = use_xnor ? 1'b0 : 1'b1;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (!e) begin
      rcnt = 0;
      case (c)
        2'd0: sym = 10'h354;
        2'd1: sym = 10'h0AB;
        2'd2: sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
    end else if (rcnt == 0 || n1q == n0q) begin
      sym[9] = ~qm[8];
      sym[8] = qm[8];
      sym[7:0] = qm[8] ? qm[7:0] : ~qm[7:0];
      if (qm[8]) rcnt = rcnt + n1q - n0q;
      else       rcnt = rcnt + n0q - n1q;
    end else if ((rcnt > 0 && n1q > n0q) ||
                 (rcnt < 0 && n0q > n1q)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      rcnt = rcnt + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      rcnt = rcnt - 2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, r;
    q = s[9] ? ~s[7:0] : s[7:0];
    r[0] = q[0];
    for (int i = 1; i < 8; i++)
      r[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return r;
  endfunction

  initial begin
    vec_t e, nv;
    logic [9:0] sym;
    int pos, cv;
    n_chk = 0;
    n_pass = 0;
    rcnt = 0;
    sys_rst_n = 1'b0;
    drive(1'b1, 2'b00, 8'h00);

    // reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 2'($urandom), 8'($urandom));
      tick();
      check("rst_hold", 32'(data_out), 32'h0);
    end
    check("rst_cnt", int'(dut.cnt_q), 0);

    drive(1'b0, 2'b00, 8'h00);
    sys_rst_n = 1'b1;
    tick();
    check("post_rst", 32'(data_out), 32'h354);
    tick(); tick();

    // control tokens
    drive(1'b0, 2'b00, 8'h00); tick();
    drive(1'b0, 2'b01, 8'h00); tick();
    drive(1'b0, 2'b10, 8'h00); tick();
    check("tok00", 32'(data_out), 32'h354);
    drive(1'b0, 2'b11, 8'h00); tick();
    check("tok01", 32'(data_out), 32'h0AB);
    drive(1'b0, 2'b00, 8'h00); tick();
    check("tok10", 32'(data_out), 32'h154);
    tick();
    check("tok11", 32'(data_out), 32'h2AB);
    tick(); tick();

    // disparity tracking on 8'h00
    drive(1'b1, 2'b00, 8'h00); tick(); tick(); tick();
    check("z0_sym", 32'(data_out), 32'h100);
    check("z0_cnt", int'(dut.cnt_q), -8);
    drive(1'b0, 2'b00, 8'h00); tick();
    check("z1_sym", 32'(data_out), 32'h3FF);
    check("z1_cnt", int'(dut.cnt_q), 2);
    tick();
    check("z2_sym", 32'(data_out), 32'h100);
    check("z2_cnt", int'(dut.cnt_q), -6);
    tick();
    check("z_blank", int'(dut.cnt_q), 0);
    tick(); tick();

    // single all-ones pulse
    drive(1'b1, 2'b00, 8'hFF); tick();
    drive(1'b0, 2'b00, 8'h00); tick(); tick();
    check("ff_sym", 32'(data_out), 32'h200);
    check("ff_cnt", int'(dut.cnt_q), -8);
    tick();
    check("ff_tok", 32'(data_out), 32'h354);
    check("ff_cnt0", int'(dut.cnt_q), 0);

    // reset mid-stream
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b00, 8'($urandom));
      tick();
    end
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst", 32'(data_out), 32'h0);
    check("mid_cnt", int'(dut.cnt_q), 0);
    tick();
    check("mid_hold", 32'(data_out), 32'h0);
    drive(1'b1, 2'b00, 8'h00);
    sys_rst_n = 1'b1;
    tick();
    check("mid_s1", 32'(data_out), 32'h354);
    drive(1'b0, 2'b00, 8'h00);
    tick(); tick();
    check("mid_s3", 32'(data_out), 32'h100);
    check("mid_cnt3", int'(dut.cnt_q), -8);

    // reference-model sweep
    drive(1'b0, 2'b00, 8'h00);
    tick(); tick(); tick(); tick();
    rcnt = 0;
    pq.delete();
    for (int i = 0; i < 3; i++) pq.push_back('0);
    for (int k = 0; k < 10000; k++) begin
      pos = k % 800;
      nv.de = (pos < 640);
      nv.last = (pos == 639);
      nv.c = 2'($urandom);
      nv.d = 8'($urandom);
      tick();
      e = pq.pop_front();
      ref_enc(e.de, e.c, e.d, sym);
      check("sweep", 32'(data_out), 32'(sym));
      check("sw_cnt", int'(dut.cnt_q), rcnt);
      if (e.de)
        check("decode", 32'(decode(data_out)), 32'(e.d));
      if (e.last) begin
        cv = int'(dut.cnt_q);
        check("cnt_bound", 32'(cv <= 8 && cv >= -8), 32'd1);
      end
      drive(nv.de, nv.c, nv.d);
      pq.push_back(nv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
